// File: rtl/fp_addsub_pkg.sv
// Shared constants for the floating-point add/sub datapath (execute stage and
// normalise/round stage).
package fp_addsub_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int BIAS    = 127;
  localparam int SW      = MAN_W + 3;
  localparam int EXP_MAX = (1 << EXP_W) - 2;
  localparam int EXP_INF = (1 << EXP_W) - 1;
  localparam int RES_W   = 1 + EXP_W + MAN_W;
  localparam int EXP_SW  = EXP_W + 2;
  localparam int LZ_W    = $clog2(SW) + 1;

  // Normalised operand handed from stage 1 to stage 2; the hidden bit is
  // implied except for an exact zero, which the zero marker carries instead.
  typedef struct packed {
    logic [MAN_W-1:0]  frac;
    logic              guard;
    logic              sticky;
    logic              sgn;
    logic [EXP_SW-1:0] exp;
    logic              zero;
  } norm_t;

  function automatic logic [RES_W-1:0] pack_word(
    input logic             sgn,
    input logic [EXP_W-1:0] exp,
    input logic [MAN_W-1:0] frac
  );
    return {sgn, exp, frac};
  endfunction

endpackage

// File: rtl/fp_addsub_lzc.sv
// Leading-zero counter, log-depth tree. An all-zero input reports W.
module fp_addsub_lzc #(
  parameter int W = 26
) (
  input  logic [W-1:0]        in_bits,
  output logic [$clog2(W):0]  count
);

  localparam int L = $clog2(W);
  localparam int P = 1 << L;

  logic [P-1:0]        padded;
  logic [P-1:0][L:0]   cur;
  logic [P-1:0][L:0]   nxt;
  logic [L:0]          half;

  // Pad below the LSB with ones so the padding never adds to the count.
  always_comb begin
    padded = '1;
    padded[P-1 -: W] = in_bits;
  end

  always_comb begin
    cur  = '0;
    nxt  = '0;
    half = '0;
    for (int i = 0; i < P; i++) begin
      cur[i] = {{L{1'b0}}, ~padded[i]};
    end
    for (int lvl = 1; lvl <= L; lvl++) begin
      half = (L+1)'(1 << (lvl - 1));
      nxt  = '0;
      for (int i = 0; i < (P >> lvl); i++) begin
        nxt[i] = (cur[2*i+1] == half) ? half + cur[2*i] : cur[2*i+1];
      end
      cur = nxt;
    end
    count = cur[0];
  end

endmodule

// File: rtl/fp_addsub_normalize_round.sv
// Normalise / round-to-nearest-even / pack stage following the add/sub
// execute stage. Two register stages with valid/ready flow control.
module fp_addsub_normalize_round
  import fp_addsub_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SW-1:0]     in_sum,
  input  logic              in_sticky,
  input  logic              in_sgn,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  out_result,
  output logic              out_overflow,
  output logic              out_underflow
);

  logic              s1_load;
  logic              s2_load;

  logic [LZ_W-1:0]   lz_count;
  logic [LZ_W-1:0]   lz_m1;
  logic [SW-2:0]     sum_shl;
  logic              norm_hidden;
  norm_t             norm;

  norm_t             s1_d, s1_q;
  logic              s1_valid_d, s1_valid_q;

  logic              round_up;
  logic              frac_carry;
  logic [MAN_W-1:0]  frac_rnd;
  logic [EXP_SW-1:0] exp_rnd;

  logic              s2_valid_d, s2_valid_q;
  logic [RES_W-1:0]  out_result_d, out_result_q;
  logic              out_overflow_d, out_overflow_q;
  logic              out_underflow_d, out_underflow_q;

  fp_addsub_lzc #(.W(SW)) u_lzc (
    .in_bits (in_sum),
    .count   (lz_count)
  );

  // out_ready reaches in_ready combinationally so a full pipe can still take
  // a new word in the same cycle the downstream drains one.
  always_comb begin
    s2_load  = !s2_valid_q || out_ready;
    s1_load  = !s1_valid_q || s2_load;
    in_ready = s1_load;
  end

  // With a carry (no leading zeros) the sum shifts right one place; otherwise
  // it shifts left N-1. The carry bit is zero on the left-shift path, so it is
  // dropped before shifting.
  always_comb begin
    lz_m1   = lz_count - LZ_W'(1);
    sum_shl = in_sum[SW-2:0] << lz_m1;
    norm    = '0;
    if (lz_count == '0) begin
      norm_hidden = in_sum[SW-1];
      norm.frac   = in_sum[SW-2:2];
      norm.guard  = in_sum[1];
      norm.sticky = in_sticky | in_sum[0];
    end else begin
      norm_hidden = sum_shl[SW-2];
      norm.frac   = sum_shl[SW-3:1];
      norm.guard  = sum_shl[0];
      norm.sticky = in_sticky;
    end
    norm.sgn  = in_sgn;
    norm.exp  = EXP_SW'(in_exp) + EXP_SW'(1) - EXP_SW'(lz_count);
    norm.zero = !norm_hidden;
  end

  always_comb begin
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_d = norm;
      end
    end
  end

  // A carry out of the fraction means 1.11..1 rounded up to 2.0, which packs
  // as fraction zero with the exponent bumped by one.
  always_comb begin
    round_up               = s1_q.guard & (s1_q.sticky | s1_q.frac[0]);
    {frac_carry, frac_rnd} = {1'b0, s1_q.frac} + (MAN_W+1)'(round_up);
    exp_rnd                = s1_q.exp + EXP_SW'(frac_carry);
  end

  always_comb begin
    s2_valid_d      = s2_valid_q;
    out_result_d    = out_result_q;
    out_overflow_d  = out_overflow_q;
    out_underflow_d = out_underflow_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_overflow_d  = 1'b0;
        out_underflow_d = 1'b0;
        if (s1_q.zero) begin
          out_result_d = '0;
        end else if (exp_rnd[EXP_SW-1] || (exp_rnd == '0)) begin
          out_result_d    = {s1_q.sgn, (RES_W-1)'(0)};
          out_underflow_d = 1'b1;
        end else if (exp_rnd > EXP_SW'(EXP_MAX)) begin
          out_result_d   = pack_word(s1_q.sgn, EXP_W'(EXP_INF), '0);
          out_overflow_d = 1'b1;
        end else begin
          out_result_d = pack_word(s1_q.sgn, exp_rnd[EXP_W-1:0], frac_rnd);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q      <= 1'b0;
      s1_q            <= '0;
      s2_valid_q      <= 1'b0;
      out_result_q    <= '0;
      out_overflow_q  <= 1'b0;
      out_underflow_q <= 1'b0;
    end else begin
      s1_valid_q      <= s1_valid_d;
      s1_q            <= s1_d;
      s2_valid_q      <= s2_valid_d;
      out_result_q    <= out_result_d;
      out_overflow_q  <= out_overflow_d;
      out_underflow_q <= out_underflow_d;
    end
  end

  always_comb begin
    out_valid     = s2_valid_q;
    out_result    = out_result_q;
    out_overflow  = out_overflow_q;
    out_underflow = out_underflow_q;
  end

endmodule

// File: tb/tb_fp_addsub_normalize_round.sv
// Scoreboard bench for the normalise/round/pack stage: directed corner cases,
// randomised traffic with backpressure, stall and mid-flight reset.
module tb_fp_addsub_normalize_round;
  import fp_addsub_pkg::*;

  typedef struct packed {
    logic [RES_W-1:0] result;
    logic             ovf;
    logic             unf;
  } exp_t;

  typedef struct packed {
    logic [SW-1:0]    sum;
    logic             sticky;
    logic             sgn;
    logic [EXP_W-1:0] exp;
    logic [RES_W-1:0] result;
    logic             ovf;
    logic             unf;
  } vec_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [SW-1:0]    in_sum;
  logic             in_sticky;
  logic             in_sgn;
  logic [EXP_W-1:0] in_exp;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] out_result;
  logic             out_overflow;
  logic             out_underflow;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  exp_t sb[$];
  logic rand_bp  = 1'b0;

  vec_t dir_vecs [20] = '{
    '{26'h2000000, 1'b0, 1'b0, 8'h7F, 32'h40000000, 1'b0, 1'b0},
    '{26'h0000002, 1'b0, 1'b1, 8'h7F, 32'hB4000000, 1'b0, 1'b0},
    '{26'h1000001, 1'b0, 1'b0, 8'h7F, 32'h3F800000, 1'b0, 1'b0},
    '{26'h1000003, 1'b0, 1'b0, 8'h7F, 32'h3F800002, 1'b0, 1'b0},
    '{26'h1FFFFFF, 1'b0, 1'b0, 8'h7F, 32'h40000000, 1'b0, 1'b0},
    '{26'h2000000, 1'b0, 1'b0, 8'hFE, 32'h7F800000, 1'b1, 1'b0},
    '{26'h0000002, 1'b0, 1'b0, 8'h0A, 32'h00000000, 1'b0, 1'b1},
    '{26'h0000000, 1'b0, 1'b1, 8'h7F, 32'h00000000, 1'b0, 1'b0},
    '{26'h0000000, 1'b1, 1'b1, 8'h7F, 32'h00000000, 1'b0, 1'b0},
    '{26'h1000001, 1'b1, 1'b0, 8'h7F, 32'h3F800001, 1'b0, 1'b0},
    '{26'h2000003, 1'b0, 1'b0, 8'h7F, 32'h40000001, 1'b0, 1'b0},
    '{26'h2000002, 1'b0, 1'b0, 8'h7F, 32'h40000000, 1'b0, 1'b0},
    '{26'h2000006, 1'b0, 1'b0, 8'h7F, 32'h40000002, 1'b0, 1'b0},
    '{26'h1FFFFFF, 1'b0, 1'b0, 8'hFE, 32'h7F800000, 1'b1, 1'b0},
    '{26'h1FFFFFF, 1'b0, 1'b1, 8'hFE, 32'hFF800000, 1'b1, 1'b0},
    '{26'h0000002, 1'b0, 1'b1, 8'h0A, 32'h80000000, 1'b0, 1'b1},
    '{26'h1000000, 1'b0, 1'b0, 8'h01, 32'h00800000, 1'b0, 1'b0},
    '{26'h0800000, 1'b0, 1'b0, 8'h01, 32'h00000000, 1'b0, 1'b1},
    '{26'h3FFFFFF, 1'b0, 1'b0, 8'h7F, 32'h40800000, 1'b0, 1'b0},
    '{26'h2000000, 1'b0, 1'b1, 8'hFD, 32'hFF000000, 1'b0, 1'b0}
  };

  fp_addsub_normalize_round dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sum        (in_sum),
    .in_sticky     (in_sticky),
    .in_sgn        (in_sgn),
    .in_exp        (in_exp),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  // Reference: locate the MSB, align it so the fraction, guard and sticky
  // fall at fixed positions, then round and range-check.
  function automatic exp_t modelResult(input logic [SW-1:0] sum, input logic st,
                                       input logic sg, input logic [EXP_W-1:0] e);
    exp_t              r;
    int                p;
    int                ee;
    longint unsigned   a;
    logic [22:0]       fr;
    logic              g;
    logic              s;
    logic [23:0]       m;
    r = '0;
    if (sum == '0) return r;
    p = 0;
    for (int i = 0; i < SW; i++) if (sum[i]) p = i;
    a  = 64'(sum) << (40 - p);
    fr = a[39:17];
    g  = a[16];
    s  = (a[15:0] != 16'h0) || st;
    ee = int'(e) + p - 24;
    m  = {1'b0, fr} + 24'((g && (s || fr[0])) ? 1 : 0);
    if (m[23]) ee = ee + 1;
    if (ee < 1) begin
      r.result = {sg, 31'h0};
      r.unf    = 1'b1;
    end else if (ee >= 255) begin
      r.result = {sg, 8'hFF, 23'h0};
      r.ovf    = 1'b1;
    end else begin
      r.result = {sg, 8'(ee), m[22:0]};
    end
    return r;
  endfunction

  task automatic applyStimulus(input logic [SW-1:0] sum, input logic st, input logic sg,
                               input logic [EXP_W-1:0] e, input exp_t want);
    logic rdy;
    bit   done;
    done = 0;
    @(negedge clk);
    in_valid  = 1'b1;
    in_sum    = sum;
    in_sticky = st;
    in_sgn    = sg;
    in_exp    = e;
    for (int c = 0; c < 200 && !done; c++) begin
      #1;
      rdy = in_ready;
      @(posedge clk);
      if (rdy) begin
        sb.push_back(want);
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) checkOutput("accept_timeout", in_ready, 1);
  endtask

  task automatic waitDrain();
    for (int c = 0; c < 300 && sb.size() != 0; c++) @(negedge clk);
    checkOutput("drain_empty", sb.size(), 0);
  endtask

  task automatic latencyProbe(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    checkOutput({tag, "_cyc1_valid"}, out_valid, 0);
    @(negedge clk);
    #2;
    checkOutput({tag, "_cyc2_valid"}, out_valid, 1);
  endtask

  // Output monitor: pops on handshake, checks held value while stalled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid) begin
        if (sb.size() == 0) begin
          checkOutput("sb_underrun_valid", out_valid, 0);
        end else if (out_ready) begin
          e = sb.pop_front();
          checkOutput($sformatf("result#%0d", n_out), out_result, e.result);
          checkOutput($sformatf("ovf#%0d", n_out), out_overflow, e.ovf);
          checkOutput($sformatf("unf#%0d", n_out), out_underflow, e.unf);
          n_out++;
        end else begin
          checkOutput("stall_hold", out_result, sb[0].result);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    logic [SW-1:0]    rs;
    logic [EXP_W-1:0] re;
    logic             rst_bit;
    logic             rsg;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sum    = '0;
    in_sticky = 1'b0;
    in_sgn    = 1'b0;
    in_exp    = '0;
    out_ready = 1'b1;

    #3;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_result", out_result, 0);
    checkOutput("rst_ovf", out_overflow, 0);
    checkOutput("rst_unf", out_underflow, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_in_ready", in_ready, 1);

    $display("[TB] latency");
    applyStimulus(26'h2000000, 1'b0, 1'b0, 8'h7F, '{32'h40000000, 1'b0, 1'b0});
    latencyProbe("lat");
    waitDrain();

    $display("[TB] directed vectors");
    foreach (dir_vecs[i]) begin
      applyStimulus(dir_vecs[i].sum, dir_vecs[i].sticky, dir_vecs[i].sgn, dir_vecs[i].exp,
                    '{dir_vecs[i].result, dir_vecs[i].ovf, dir_vecs[i].unf});
    end
    @(negedge clk);
    in_valid = 1'b0;
    waitDrain();

    $display("[TB] random traffic with backpressure");
    rand_bp = 1'b1;
    for (int i = 0; i < 60; i++) begin
      rs      = SW'($urandom) >> $urandom_range(0, SW - 1);
      re      = EXP_W'($urandom_range(1, 254));
      rst_bit = 1'($urandom_range(0, 1));
      rsg     = 1'($urandom_range(0, 1));
      applyStimulus(rs, rst_bit, rsg, re, modelResult(rs, rst_bit, rsg, re));
    end
    @(negedge clk);
    in_valid  = 1'b0;
    rand_bp   = 1'b0;
    out_ready = 1'b1;
    waitDrain();

    $display("[TB] stalled output");
    base = n_out;
    @(negedge clk);
    out_ready = 1'b0;
    applyStimulus(26'h1000003, 1'b0, 1'b0, 8'h7F, '{32'h3F800002, 1'b0, 1'b0});
    applyStimulus(26'h0000002, 1'b0, 1'b1, 8'h7F, '{32'hB4000000, 1'b0, 1'b0});
    @(negedge clk);
    in_valid  = 1'b1;
    in_sum    = 26'h2000000;
    in_sticky = 1'b0;
    in_sgn    = 1'b0;
    in_exp    = 8'hFE;
    for (int c = 0; c < 4; c++) begin
      #1;
      checkOutput($sformatf("bp_in_ready_%0d", c), in_ready, 0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    applyStimulus(26'h2000000, 1'b0, 1'b0, 8'hFE, '{32'h7F800000, 1'b1, 1'b0});
    @(negedge clk);
    in_valid = 1'b0;
    waitDrain();
    checkOutput("bp_out_count", n_out - base, 3);

    $display("[TB] reset with both stages full");
    @(negedge clk);
    out_ready = 1'b0;
    applyStimulus(26'h1000001, 1'b1, 1'b0, 8'h7F, '{32'h3F800001, 1'b0, 1'b0});
    applyStimulus(26'h3FFFFFF, 1'b0, 1'b0, 8'h7F, '{32'h40800000, 1'b0, 1'b0});
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_out_valid", out_valid, 0);
    checkOutput("rst_mid_result", out_result, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    checkOutput("rst_mid_in_ready", in_ready, 1);
    applyStimulus(26'h0000002, 1'b0, 1'b0, 8'h0A, '{32'h00000000, 1'b0, 1'b1});
    latencyProbe("post_rst");
    waitDrain();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
